// File: rtl/stdp_learning_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stdp_learning_unit_pkg
// Brief    : Shared constants, state encoding and shift-magnitude helper
//            for the STDP learning unit.
// Revision : 1.0
// ============================================================================
package stdp_learning_unit_pkg;

    localparam int ID_W   = 4;
    localparam int AGE_W  = 4;
    localparam int N      = 1 << ID_W;
    localparam int WINDOW = 8;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] S_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] S_SCAN = 1'b1;

    // Exponential-ish decay: amplitude halves per age step, zero outside the window.
    function automatic logic [7:0] mag(input logic [7:0] amp, input logic [AGE_W-1:0] age);
        if (age >= AGE_W'(WINDOW))
            mag = 8'd0;
        else
            mag = amp >> age;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stdp_learning_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : stdp_learning_unit_if
// Brief    : Spike-event handshake plus weight-store learning port.
// Revision : 1.0
// ============================================================================
interface stdp_learning_unit_if #(
    parameter int ID_W = 4
);
    logic                spike_valid;
    logic                spike_ready;
    logic                spike_is_post;
    logic [ID_W-1:0]     spike_id;
    logic                learn_enable;
    logic [2*ID_W-1:0]   learn_addr;
    logic [7:0]          learn_delta;

    modport master (
        output spike_valid, spike_is_post, spike_id,
        input  spike_ready, learn_enable, learn_addr, learn_delta
    );

    modport slave (
        input  spike_valid, spike_is_post, spike_id,
        output spike_ready, learn_enable, learn_addr, learn_delta
    );
endinterface
`default_nettype wire

// File: rtl/stdp_learning_unit_trace_bank.sv
`default_nettype none
// ============================================================================
// Module   : stdp_trace_bank
// Brief    : N saturating age counters with tick, single-index clear and a
//            combinational read port.
// Revision : 1.0
// ============================================================================
module stdp_trace_bank #(
    parameter int ID_W   = 4,
    parameter int AGE_W  = 4,
    parameter int WINDOW = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_tick,
    input  wire logic             i_clr_en,
    input  wire logic [ID_W-1:0]  i_clr_idx,
    input  wire logic [ID_W-1:0]  i_rd_idx,
    output logic      [AGE_W-1:0] o_rd_age
);
    localparam int                c_n      = 1 << ID_W;
    localparam logic [AGE_W-1:0]  c_window = AGE_W'(WINDOW);

    logic [c_n-1:0][AGE_W-1:0] w_ages;

    generate
        for (genvar g = 0; g < c_n; g++) begin : g_age
            logic [AGE_W-1:0] r_age;

            // A clear (new spike) takes priority over a same-cycle tick.
            always_ff @(posedge clk) begin
                if (rst)
                    r_age <= c_window;
                else if (i_clr_en && (i_clr_idx == ID_W'(g)))
                    r_age <= '0;
                else if (i_tick && (r_age < c_window))
                    r_age <= r_age + AGE_W'(1);
            end

            assign w_ages[g] = r_age;
        end
    endgenerate

    assign o_rd_age = w_ages[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/stdp_learning_unit.sv
`default_nettype none
// ============================================================================
// Module   : stdp_learning_unit
// Brief    : STDP engine: per accepted spike, scans all partner traces and
//            emits signed weight deltas to the weight store.
// Revision : 1.0
// ============================================================================
module stdp_learning_unit
    import stdp_learning_unit_pkg::*;
#(
    parameter logic [7:0] A_PLUS  = 8'd32,
    parameter logic [7:0] A_MINUS = 8'd24
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           time_tick,
    input  wire logic           learn_on,
    stdp_learning_unit_if.slave bus,
    output logic                busy,
    output logic [31:0]         update_count
);
    localparam logic [ID_W-1:0] c_last_k = ID_W'(N - 1);

    logic [STATE_W-1:0]  r_state;
    logic                r_is_post;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_k;
    logic                r_learn_enable;
    logic [2*ID_W-1:0]   r_learn_addr;
    logic [7:0]          r_learn_delta;
    logic [31:0]         r_update_count;

    logic                w_accept;
    logic [AGE_W-1:0]    w_pre_age;
    logic [AGE_W-1:0]    w_post_age;
    logic [AGE_W-1:0]    w_age;
    logic [7:0]          w_amp;
    logic [7:0]          w_mag;
    logic                w_emit;
    logic [7:0]          w_delta;
    logic [2*ID_W-1:0]   w_addr;

    assign w_accept = bus.spike_valid && (r_state == S_IDLE);

    stdp_trace_bank #(.ID_W(ID_W), .AGE_W(AGE_W), .WINDOW(WINDOW)) u_pre_bank (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (time_tick),
        .i_clr_en  (w_accept && !bus.spike_is_post),
        .i_clr_idx (bus.spike_id),
        .i_rd_idx  (r_k),
        .o_rd_age  (w_pre_age)
    );

    stdp_trace_bank #(.ID_W(ID_W), .AGE_W(AGE_W), .WINDOW(WINDOW)) u_post_bank (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (time_tick),
        .i_clr_en  (w_accept && bus.spike_is_post),
        .i_clr_idx (bus.spike_id),
        .i_rd_idx  (r_k),
        .o_rd_age  (w_post_age)
    );

    // Post spike pairs with pre traces (potentiation), pre spike with post traces (depression).
    assign w_age   = r_is_post ? w_pre_age : w_post_age;
    assign w_amp   = r_is_post ? A_PLUS : A_MINUS;
    assign w_mag   = mag(w_amp, w_age);
    assign w_emit  = (r_state == S_SCAN) && learn_on && (w_mag != 8'd0);
    assign w_delta = r_is_post ? w_mag : (~w_mag + 8'd1);
    assign w_addr  = r_is_post ? {r_id, r_k} : {r_k, r_id};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_is_post      <= 1'b0;
            r_id           <= '0;
            r_k            <= '0;
            r_learn_enable <= 1'b0;
            r_learn_addr   <= '0;
            r_learn_delta  <= '0;
            r_update_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_SCAN;
                        r_is_post <= bus.spike_is_post;
                        r_id      <= bus.spike_id;
                        r_k       <= '0;
                    end
                end
                S_SCAN: begin
                    r_k <= r_k + ID_W'(1);
                    if (r_k == c_last_k)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            r_learn_enable <= w_emit;
            r_learn_addr   <= w_emit ? w_addr : '0;
            r_learn_delta  <= w_emit ? w_delta : 8'd0;
            r_update_count <= r_update_count + 32'(w_emit);
        end
    end

    assign bus.spike_ready  = (r_state == S_IDLE);
    assign bus.learn_enable = r_learn_enable;
    assign bus.learn_addr   = r_learn_addr;
    assign bus.learn_delta  = r_learn_delta;
    assign busy             = (r_state == S_SCAN);
    assign update_count     = r_update_count;

endmodule
`default_nettype wire

// File: tb/tb_stdp_learning_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdp_learning_unit
// Brief    : Directed self-checking bench for stdp_learning_unit.
// Revision : 1.0
// ============================================================================
module tb_stdp_learning_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        time_tick;
    logic        learn_on;
    logic        busy;
    logic [31:0] update_count;

    int checks = 0;
    int errors = 0;

    int         n_pulse;
    int         last_slot;
    logic [7:0] last_addr;
    logic [7:0] last_delta;
    bit         scan_bad;

    stdp_learning_unit_if #(.ID_W(4)) sif ();

    stdp_learning_unit dut (
        .clk          (clk),
        .rst          (rst),
        .time_tick    (time_tick),
        .learn_on     (learn_on),
        .bus          (sif.slave),
        .busy         (busy),
        .update_count (update_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        sif.spike_valid = 1'b0;
        time_tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            time_tick = 1'b1;
            @(posedge clk); #1;
            time_tick = 1'b0;
        end
    endtask

    // Returns at cycle T+1 (just after the accepting edge).
    task automatic accept_spike(input logic post, input logic [3:0] id);
        int waited = 0;
        sif.spike_valid   = 1'b1;
        sif.spike_is_post = post;
        sif.spike_id      = id;
        while (sif.spike_ready !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 40) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready never rose, waited %0d cycles, required < 40", waited);
        end
        @(posedge clk); #1;
        sif.spike_valid = 1'b0;
    endtask

    task automatic observe_scan();
        n_pulse = 0; last_slot = -1; last_addr = 8'h00; last_delta = 8'h00; scan_bad = 1'b0;
        for (int m = 0; m < 16; m++) begin
            if (busy !== 1'b1 || sif.spike_ready !== 1'b0) scan_bad = 1'b1;
            @(posedge clk); #1;
            if (sif.learn_enable === 1'b1) begin
                n_pulse++;
                last_slot  = m;
                last_addr  = sif.learn_addr;
                last_delta = sif.learn_delta;
            end else if (sif.learn_enable !== 1'b0 || sif.learn_addr !== 8'h00 || sif.learn_delta !== 8'h00) begin
                scan_bad = 1'b1;
            end
        end
        if (busy !== 1'b0 || sif.spike_ready !== 1'b1) scan_bad = 1'b1;
    endtask

    task automatic run_spike(input logic post, input logic [3:0] id);
        accept_spike(post, id);
        observe_scan();
    endtask

    task automatic test_reset();
        rst = 1'b1; time_tick = 1'b0; learn_on = 1'b1;
        sif.spike_valid = 1'b0; sif.spike_is_post = 1'b0; sif.spike_id = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (sif.spike_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", sif.spike_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sif.learn_enable !== 1'b0) begin errors++; $display("FAIL reset_le: got %b expected 0", sif.learn_enable); end
        checks++; if (sif.learn_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", sif.learn_addr); end
        checks++; if (sif.learn_delta !== 8'h00) begin errors++; $display("FAIL reset_delta: got %h expected 00", sif.learn_delta); end
        checks++; if (update_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", update_count); end
    endtask

    task automatic test_no_partner();
        do_reset();
        run_spike(1'b1, 4'd3);
        checks++; if (n_pulse !== 0) begin errors++; $display("FAIL nopartner_pulses: got %0d expected 0", n_pulse); end
        checks++; if (update_count !== 32'd0) begin errors++; $display("FAIL nopartner_count: got %0d expected 0", update_count); end
        checks++; if (scan_bad !== 1'b0) begin errors++; $display("FAIL nopartner_timing: got %b expected 0", scan_bad); end
    endtask

    task automatic test_potentiation();
        do_reset();
        run_spike(1'b0, 4'd5);
        tick_n(2);
        run_spike(1'b1, 4'd3);
        checks++; if (n_pulse !== 1) begin errors++; $display("FAIL ltp_pulses: got %0d expected 1", n_pulse); end
        checks++; if (last_addr !== 8'h35) begin errors++; $display("FAIL ltp_addr: got %h expected 35", last_addr); end
        checks++; if (last_delta !== 8'h08) begin errors++; $display("FAIL ltp_delta: got %h expected 08", last_delta); end
        checks++; if (last_slot !== 5) begin errors++; $display("FAIL ltp_slot: got %0d expected 5", last_slot); end
        checks++; if (update_count !== 32'd1) begin errors++; $display("FAIL ltp_count: got %0d expected 1", update_count); end
        checks++; if (scan_bad !== 1'b0) begin errors++; $display("FAIL ltp_timing: got %b expected 0", scan_bad); end
    endtask

    task automatic test_depression();
        do_reset();
        run_spike(1'b1, 4'd2);
        tick_n(1);
        run_spike(1'b0, 4'd7);
        checks++; if (n_pulse !== 1) begin errors++; $display("FAIL ltd_pulses: got %0d expected 1", n_pulse); end
        checks++; if (last_addr !== 8'h27) begin errors++; $display("FAIL ltd_addr: got %h expected 27", last_addr); end
        checks++; if (last_delta !== 8'hF4) begin errors++; $display("FAIL ltd_delta: got %h expected f4", last_delta); end
        checks++; if (last_slot !== 2) begin errors++; $display("FAIL ltd_slot: got %0d expected 2", last_slot); end
    endtask

    task automatic test_saturation_and_gate();
        do_reset();
        run_spike(1'b0, 4'd1);
        tick_n(11);
        run_spike(1'b1, 4'd0);
        checks++; if (n_pulse !== 0) begin errors++; $display("FAIL sat_pulses: got %0d expected 0", n_pulse); end
        learn_on = 1'b0;
        run_spike(1'b0, 4'd1);
        checks++; if (n_pulse !== 0) begin errors++; $display("FAIL off_pre_pulses: got %0d expected 0", n_pulse); end
        run_spike(1'b1, 4'd0);
        checks++; if (n_pulse !== 0) begin errors++; $display("FAIL off_post_pulses: got %0d expected 0", n_pulse); end
        checks++; if (update_count !== 32'd0) begin errors++; $display("FAIL off_count: got %0d expected 0", update_count); end
        learn_on = 1'b1;
        // Same traces, gate reopened: post 0 at age 0 vs pre 1 -> full-amplitude depression.
        run_spike(1'b0, 4'd1);
        checks++; if (last_delta !== 8'hE8 || n_pulse !== 1) begin errors++; $display("FAIL on_delta: got %h/%0d expected e8/1", last_delta, n_pulse); end
    endtask

    task automatic test_shift_boundary();
        do_reset();
        run_spike(1'b0, 4'd4);
        tick_n(5);
        run_spike(1'b1, 4'd9);
        checks++; if (last_delta !== 8'h01 || last_addr !== 8'h94 || n_pulse !== 1) begin errors++; $display("FAIL ltp_age5: got %h/%h/%0d expected 01/94/1", last_delta, last_addr, n_pulse); end
        tick_n(1);
        run_spike(1'b1, 4'd9);
        checks++; if (n_pulse !== 0) begin errors++; $display("FAIL ltp_age6_pulses: got %0d expected 0", n_pulse); end
        do_reset();
        run_spike(1'b1, 4'd6);
        tick_n(4);
        run_spike(1'b0, 4'd2);
        checks++; if (last_delta !== 8'hFF || last_addr !== 8'h62 || n_pulse !== 1) begin errors++; $display("FAIL ltd_age4: got %h/%h/%0d expected ff/62/1", last_delta, last_addr, n_pulse); end
        tick_n(1);
        run_spike(1'b0, 4'd2);
        checks++; if (n_pulse !== 0) begin errors++; $display("FAIL ltd_age5_pulses: got %0d expected 0", n_pulse); end
    endtask

    task automatic test_back_to_back();
        bit ready_early = 1'b0;
        do_reset();
        run_spike(1'b0, 4'd5);
        tick_n(2);
        sif.spike_valid = 1'b1; sif.spike_is_post = 1'b1; sif.spike_id = 4'd3;
        @(posedge clk); #1;
        sif.spike_id = 4'd4;
        for (int m = 1; m <= 16; m++) begin
            if (sif.spike_ready !== 1'b0) ready_early = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (ready_early !== 1'b0) begin errors++; $display("FAIL b2b_ready_early: got %b expected 0", ready_early); end
        checks++; if (sif.spike_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t17: got %b expected 1", sif.spike_ready); end
        @(posedge clk); #1;
        sif.spike_valid = 1'b0;
        observe_scan();
        checks++; if (last_addr !== 8'h45 || last_delta !== 8'h08 || n_pulse !== 1) begin errors++; $display("FAIL b2b_second: got %h/%h/%0d expected 45/08/1", last_addr, last_delta, n_pulse); end
        checks++; if (update_count !== 32'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", update_count); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        run_spike(1'b0, 4'd5);
        tick_n(2);
        accept_spike(1'b1, 4'd3);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (sif.learn_enable !== 1'b0 || busy !== 1'b0 || sif.spike_ready !== 1'b1) begin errors++; $display("FAIL midrst_state: got le=%b busy=%b rdy=%b expected 0/0/1", sif.learn_enable, busy, sif.spike_ready); end
        @(posedge clk); #1;
        checks++; if (sif.learn_enable !== 1'b0) begin errors++; $display("FAIL midrst_slot5: got %b expected 0", sif.learn_enable); end
        run_spike(1'b1, 4'd3);
        checks++; if (n_pulse !== 0 || update_count !== 32'd0) begin errors++; $display("FAIL midrst_rescan: got %0d/%0d expected 0/0", n_pulse, update_count); end
    endtask

    initial begin
        test_reset();
        test_no_partner();
        test_potentiation();
        test_depression();
        test_saturation_and_gate();
        test_shift_boundary();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
